// File: rtl/dump_pkg.sv
// Shared definitions for the memory dump engine.
// Holds the FSM state encoding, the dump mode encodings, the source codes used
// on the output stream, and a small helper that decodes a mode.
package dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    MODE_ALL = 2'b00,  // RAM then RF
    MODE_RAM = 2'b01,  // RAM only
    MODE_RF  = 2'b10,  // RF only
    MODE_NZ  = 2'b11   // RAM then RF, zero-valued entries skipped
  } mode_t;

  localparam logic SRC_RAM = 1'b0;
  localparam logic SRC_RF  = 1'b1;

  // True when the dump continues into the register file after the RAM.
  function automatic logic mode_has_rf(input mode_t m);
    return m != MODE_RAM;
  endfunction

endpackage

// File: rtl/mem_dump_engine_if.sv
// Dump output stream: one entry per valid/ready beat.
//   out_valid/out_src/out_addr/out_data : payload, driven by the engine (master)
//   out_ready                           : back-pressure, driven by the consumer (slave)
// out_src is 0 for a RAM entry and 1 for a register-file entry.
interface mem_dump_engine_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 8
);
  logic              out_valid;
  logic              out_src;
  logic [AW-1:0]     out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, out_src, out_addr, out_data, input out_ready);
  modport slave  (input out_valid, out_src, out_addr, out_data, output out_ready);
endinterface

// File: rtl/dump_out_stage.sv
// Valid/ready holding register for the dump stream.
//   load    : capture a new entry and raise out_valid
//   flush   : drop out_valid immediately (abort); payload is kept
//   in_*    : entry to capture on load
//   dump    : stream master; payload stays stable while out_valid && !out_ready
module dump_out_stage
  import dump_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic              flush,
  input  logic              in_src,
  input  logic [AW-1:0]     in_addr,
  input  logic [DATA_W-1:0] in_data,
  mem_dump_engine_if.master dump
);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      dump.out_valid <= 1'b0;
      dump.out_src   <= SRC_RAM;
      dump.out_addr  <= '0;
      dump.out_data  <= '0;
    end else if (flush) begin
      dump.out_valid <= 1'b0;
    end else if (load) begin
      dump.out_valid <= 1'b1;
      dump.out_src   <= in_src;
      dump.out_addr  <= in_addr;
      dump.out_data  <= in_data;
    end else if (dump.out_valid && dump.out_ready) begin
      dump.out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_dump_engine.sv
// Memory dump engine: freezes the CPU, then walks the RAM and/or register file
// through their 1-cycle-latency read ports and streams every entry out.
//   clk, areset            : clock, asynchronous active-low reset
//   start, mode, abort     : dump request, dump selection, cancel
//   halt_req / halt_ack    : CPU freeze handshake
//   ram_rd_* / rf_rd_*     : read ports (data valid the cycle after rd_en)
//   dump                   : output stream (valid/ready)
//   busy, done, count      : status; done pulses once, count = entries emitted
module mem_dump_engine
  import dump_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 16,
  parameter int RF_DEPTH  = 8,
  parameter int AW        = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic              ram_rd_en,
  output logic [AW-1:0]     ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              rf_rd_en,
  output logic [AW-1:0]     rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  mem_dump_engine_if.master dump,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       count
);

  state_t            state;
  mode_t             mode_q;
  logic              src;
  logic [AW-1:0]     idx;

  logic [DATA_W-1:0] cap_data;
  logic              flush, skip, load, advance, issue;
  logic              adv_finish, adv_src, next_src;
  logic [AW-1:0]     adv_idx, next_idx;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    cap_data   = (src == SRC_RF) ? rf_rd_data : ram_rd_data;
    adv_src    = src;
    adv_idx    = idx + 1'b1;
    adv_finish = 1'b0;

    // Where the walk goes after the current entry; the index never wraps.
    if (src == SRC_RAM) begin
      if (idx == AW'(RAM_DEPTH - 1)) begin
        if (mode_has_rf(mode_q)) begin
          adv_src = SRC_RF;
          adv_idx = '0;
        end else begin
          adv_finish = 1'b1;
        end
      end
    end else if (idx == AW'(RF_DEPTH - 1)) begin
      adv_finish = 1'b1;
    end

    flush   = abort && (state != S_IDLE);
    skip    = (state == S_CAPTURE) && (mode_q == MODE_NZ) && (cap_data == '0);
    load    = (state == S_CAPTURE) && !skip && !flush;
    // abort wins over a same-edge handshake, so that beat is neither advanced nor counted.
    advance = !flush && (skip || ((state == S_SEND) && dump.out_ready));
    issue   = !flush && (((state == S_HALT) && halt_ack) || (advance && !adv_finish));

    // First read after the halt uses the index set up at start; later reads use the advance.
    next_src = (state == S_HALT) ? src : adv_src;
    next_idx = (state == S_HALT) ? idx : adv_idx;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state       <= S_IDLE;
      mode_q      <= MODE_ALL;
      src         <= SRC_RAM;
      idx         <= '0;
      halt_req    <= 1'b0;
      done        <= 1'b0;
      ram_rd_en   <= 1'b0;
      rf_rd_en    <= 1'b0;
      ram_rd_addr <= '0;
      rf_rd_addr  <= '0;
      count       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      ram_rd_en <= 1'b0;
      rf_rd_en  <= 1'b0;
      done      <= 1'b0;

      // Read strobes are registered on entry to ISSUE, so they are high exactly in ISSUE.
      if (issue) begin
        src <= next_src;
        idx <= next_idx;
        if (next_src == SRC_RF) begin
          rf_rd_en   <= 1'b1;
          rf_rd_addr <= next_idx;
        end else begin
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= next_idx;
        end
      end

      if (flush) begin
        state    <= S_IDLE;
        halt_req <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_HALT;
              mode_q   <= mode_t'(mode);
              count    <= '0;
              halt_req <= 1'b1;
              idx      <= '0;
              src      <= (mode_t'(mode) == MODE_RF) ? SRC_RF : SRC_RAM;
            end
          end
          S_HALT:    if (halt_ack) state <= S_ISSUE;
          S_ISSUE:   state <= S_CAPTURE;
          S_CAPTURE: if (!skip) state <= S_SEND;
          S_SEND: begin
            if (dump.out_ready && (count != '1)) count <= count + 1'b1;
          end
          S_FINISH:  state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase

        if (advance) begin
          state <= adv_finish ? S_FINISH : S_ISSUE;
          if (adv_finish) begin
            halt_req <= 1'b0;
            done     <= 1'b1;
          end
        end
      end
    end
  end

  dump_out_stage #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_out_stage (
    .clk     (clk),
    .areset  (areset),
    .load    (load),
    .flush   (flush),
    .in_src  (src),
    .in_addr (idx),
    .in_data (cap_data),
    .dump    (dump)
  );

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed self-checking bench for mem_dump_engine (default parameters).
// Models the RAM and register file as 1-cycle-latency read ports and walks
// the dump modes, back-pressure, delayed halt, abort and async reset.
module tb_mem_dump_engine;

  localparam int DUMP_LIMIT = 400;

  logic       clk;
  logic       areset;
  logic       start;
  logic [1:0] mode;
  logic       abort;
  logic       halt_req;
  logic       halt_ack;
  logic       ram_rd_en;
  logic [7:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic       rf_rd_en;
  logic [7:0] rf_rd_addr;
  logic [7:0] rf_rd_data;
  logic       busy;
  logic       done;
  logic [8:0] count;

  mem_dump_engine_if #(.DATA_W(8), .AW(8)) dump_if ();

  mem_dump_engine #(
    .DATA_W    (8),
    .RAM_DEPTH (16),
    .RF_DEPTH  (8),
    .AW        (8)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .start       (start),
    .mode        (mode),
    .abort       (abort),
    .halt_req    (halt_req),
    .halt_ack    (halt_ack),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .rf_rd_en    (rf_rd_en),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .dump        (dump_if),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models with registered (1-cycle) reads.
  logic [7:0] ram [0:255];
  logic [7:0] rf  [0:255];

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    if (rf_rd_en)  rf_rd_data  <= rf[rf_rd_addr];
  end

  int overlap_err = 0;
  always @(negedge clk) begin
    if (ram_rd_en && rf_rd_en) overlap_err++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent run_dump.
  logic [16:0] beat_q[$];
  int          done_cnt;
  int          stable_err;
  int          hs_err;
  int          first_cyc;
  int          last_cyc;

  function automatic logic [16:0] beat_at(input int i);
    if (i < beat_q.size()) return beat_q[i];
    return 17'h1ffff;
  endfunction

  task automatic fill_mem(input bit zero);
    for (int i = 0; i < 256; i++) begin
      ram[i] = zero ? 8'h00 : 8'(i + 1);
      rf[i]  = zero ? 8'h00 : 8'(8'h80 + i);
    end
  endtask

  // Starts a dump and runs it to completion, recording every accepted beat.
  // ready_mode 0: out_ready always 1; 1: out_ready toggles 1-0-1-0.
  // ack_delay: cycles after start before halt_ack goes high.
  // restart_at: cycle at which a (to-be-ignored) start with mode 01 is pulsed; -1 for none.
  task automatic run_dump(input logic [1:0] m, input int ready_mode, input int ack_delay,
                          input int restart_at, input string tag);
    int          post;
    logic        stalled;
    logic [16:0] held;
    logic [16:0] cur;
    beat_q.delete();
    done_cnt   = 0;
    stable_err = 0;
    hs_err     = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    stalled    = 1'b0;
    held       = '0;
    post       = 0;
    halt_ack   = (ack_delay == 0);
    dump_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_count_clear"}, 64'(count), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int cyc = 0; cyc < DUMP_LIMIT; cyc++) begin
      halt_ack = (cyc >= ack_delay);
      start    = (cyc == restart_at);
      if (cyc == restart_at) mode = 2'b01;
      dump_if.out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (cyc <= ack_delay && (ram_rd_en || rf_rd_en || !halt_req)) hs_err++;
      cur = {dump_if.out_src, dump_if.out_addr, dump_if.out_data};
      if (stalled && ({dump_if.out_valid, cur} !== {1'b1, held})) stable_err++;
      if (dump_if.out_valid && dump_if.out_ready) begin
        beat_q.push_back(cur);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      stalled = dump_if.out_valid && !dump_if.out_ready;
      held    = cur;
      if (done) done_cnt++;
      if (done_cnt > 0) begin
        post++;
        if (post > 3) break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_finished"}, 64'(done_cnt != 0), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_halt_req_low"}, 64'(halt_req), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_stable"}, 64'(stable_err), 64'd0);
    check({tag, "_halt_handshake"}, 64'(hs_err), 64'd0);
  endtask

  initial begin
    logic found;
    areset   = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    abort    = 1'b0;
    halt_ack = 1'b0;
    dump_if.out_ready = 1'b0;
    fill_mem(1'b0);

    // Reset state.
    #2 areset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags", 64'({busy, done, halt_req, dump_if.out_valid, ram_rd_en, rf_rd_en,
                            dump_if.out_src}), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out", 64'({dump_if.out_addr, dump_if.out_data}), 64'd0);
    areset = 1'b1;

    // Mode 00, full-rate: RAM 0..15 then RF 0..7.
    run_dump(2'b00, 0, 0, -1, "all");
    check("all_beats", 64'(beat_q.size()), 64'd24);
    for (int i = 0; i < 16; i++)
      check($sformatf("all_ram%0d", i), 64'(beat_at(i)), 64'({1'b0, 8'(i), 8'(i + 1)}));
    for (int i = 0; i < 8; i++)
      check($sformatf("all_rf%0d", i), 64'(beat_at(16 + i)), 64'({1'b1, 8'(i), 8'(8'h80 + i)}));
    check("all_count", 64'(count), 64'd24);
    check("all_beat_span", 64'(last_cyc - first_cyc), 64'd69);

    // Mode 11, only two nonzero entries.
    fill_mem(1'b1);
    ram[3] = 8'h5A;
    rf[7]  = 8'hFF;
    run_dump(2'b11, 0, 0, -1, "nz");
    check("nz_beats", 64'(beat_q.size()), 64'd2);
    check("nz_beat0", 64'(beat_at(0)), 64'({1'b0, 8'd3, 8'h5A}));
    check("nz_beat1", 64'(beat_at(1)), 64'({1'b1, 8'd7, 8'hFF}));
    check("nz_count", 64'(count), 64'd2);
    fill_mem(1'b0);

    // Mode 10 with back-pressure, plus an ignored start while busy.
    run_dump(2'b10, 1, 0, 5, "rf");
    check("rf_beats", 64'(beat_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rf_beat%0d", i), 64'(beat_at(i)), 64'({1'b1, 8'(i), 8'(8'h80 + i)}));
    check("rf_count", 64'(count), 64'd8);

    // Mode 01 with halt_ack delayed by 10 cycles.
    run_dump(2'b01, 0, 10, -1, "ram");
    check("ram_beats", 64'(beat_q.size()), 64'd16);
    check("ram_first", 64'(beat_at(0)), 64'({1'b0, 8'd0, 8'd1}));
    check("ram_last", 64'(beat_at(15)), 64'({1'b0, 8'd15, 8'd16}));
    check("ram_count", 64'(count), 64'd16);

    // Abort while RAM index 5 is being offered.
    halt_ack = 1'b1;
    dump_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (dump_if.out_valid && dump_if.out_src == 1'b0 && dump_if.out_addr == 8'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_idx5", 64'(found), 64'd1);
    check("abort_count_before", 64'(count), 64'd5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_flags", 64'({busy, done, halt_req, dump_if.out_valid}), 64'd0);
    check("abort_count_kept", 64'(count), 64'd5);
    @(negedge clk);
    abort = 1'b0;
    check("abort_no_done", 64'(done), 64'd0);
    run_dump(2'b00, 0, 0, -1, "restart");
    check("restart_beats", 64'(beat_q.size()), 64'd24);
    check("restart_first", 64'(beat_at(0)), 64'({1'b0, 8'd0, 8'd1}));
    check("restart_count", 64'(count), 64'd24);

    // Asynchronous reset in the middle of a dump.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_pre_busy", 64'(busy), 64'd1);
    #3 areset = 1'b0;
    #1;
    check("arst_flags", 64'({busy, done, halt_req, dump_if.out_valid, ram_rd_en, rf_rd_en,
                             dump_if.out_src}), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_out", 64'({dump_if.out_addr, dump_if.out_data}), 64'd0);
    check("arst_rd_addr", 64'({ram_rd_addr, rf_rd_addr}), 64'd0);
    @(negedge clk);
    areset = 1'b1;
    run_dump(2'b00, 0, 0, -1, "post_rst");
    check("post_rst_beats", 64'(beat_q.size()), 64'd24);
    check("post_rst_count", 64'(count), 64'd24);

    check("rd_en_overlap", 64'(overlap_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_dump_engine.md
MEM_DUMP_ENGINE -- requirements
Module: mem_dump_engine

Interface
REQ-001 Parameter DATA_W, default 8, the word width of RAM and register file.
REQ-002 Parameter RAM_DEPTH, default 16, the number of RAM entries dumped.
REQ-003 Parameter RF_DEPTH, default 8, the number of register-file entries dumped.
REQ-004 Parameter AW, default 8, the address width of both read ports and of the output address; it shall be at least clog2(max(RAM_DEPTH,RF_DEPTH)).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 areset  in  1  asynchronous reset, active-low.
REQ-007 start  in  1  single-cycle dump request.
REQ-008 mode  in  2  dump selection: 00 RAM then RF, 01 RAM only, 10 RF only, 11 RAM then RF with zero entries skipped.
REQ-009 abort  in  1  cancels a dump in progress.
REQ-010 halt_req / halt_ack  out / in  1 / 1  CPU freeze handshake.
REQ-011 ram_rd_en, ram_rd_addr / ram_rd_data  out 1, AW / in DATA_W  RAM read port, 1-cycle read latency.
REQ-012 rf_rd_en, rf_rd_addr / rf_rd_data  out 1, AW / in DATA_W  register-file read port, 1-cycle read latency.
REQ-013 out_valid, out_src, out_addr, out_data / out_ready  out 1, 1, AW, DATA_W / in 1  dump stream; out_src is 0 for RAM and 1 for RF.
REQ-014 busy, done, count  out 1, 1, AW+1  status outputs; done is a one-cycle pulse; count is the number of entries emitted.

Function
REQ-015 States: IDLE, HALT, ISSUE, CAPTURE, SEND, FINISH.
REQ-016 IDLE -> HALT on start=1; mode is latched on that edge, count clears to 0, and halt_req rises.
REQ-017 start while busy=1 shall be ignored.
REQ-018 HALT: halt_req held high; HALT -> ISSUE on the first edge with halt_ack=1; the engine waits indefinitely for halt_ack.
REQ-019 ISSUE: assert exactly one rd_en for the current source and index for one cycle, then go to CAPTURE.
REQ-020 CAPTURE: register the returned data into the output stage, then go to SEND.
REQ-021 In CAPTURE with mode 11 and data==0, the engine shall skip SEND and advance directly.
REQ-022 SEND: out_valid=1 with payload held stable until the edge where out_ready=1, then advance; count increments on that edge.
REQ-023 Minimum cost per emitted entry is 3 cycles when out_ready is held at 1.
REQ-024 Advance: the index increments; on the last RAM index (RAM_DEPTH-1) the engine switches to RF index 0 if the mode includes RF, otherwise it goes to FINISH.
REQ-025 On the last RF index (RF_DEPTH-1) the engine goes to FINISH; the index never wraps within a source.
REQ-026 FINISH: drop halt_req, pulse done for one cycle, go to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 abort=1 in any non-IDLE state: next edge -> IDLE, out_valid=0, halt_req=0, no done pulse, count retains its value.
REQ-029 abort has priority over out_ready on the same edge; a beat accepted on an abort edge does not count.
REQ-030 rd_en shall never be asserted outside ISSUE; the two rd_en signals are never high together.
REQ-031 count saturates at 2^(AW+1)-1.

Reset
REQ-032 areset low asynchronously forces: state=IDLE, busy=0, done=0, halt_req=0, out_valid=0, ram_rd_en=0, rf_rd_en=0, count=0, the index, both rd_addr outputs, out_addr and out_data to 0, out_src=0.
REQ-033 Reset release is sampled synchronously; the first start is accepted on the first edge after release.

Structure
REQ-034 Package dump_pkg shall hold the state enum, the mode encodings (MODE_ALL, MODE_RAM, MODE_RF, MODE_NZ) and the source codes SRC_RAM/SRC_RF.
REQ-035 One sub-module, dump_out_stage, shall be the valid/ready output holding register; the remainder is a single FSM plus index/count logic.

Verification
REQ-036 Mode 00, halt_ack tied to 1, out_ready=1, RAM[i]=i+1, RF[i]=0x80+i -> 24 beats in order (RAM 0..15 then RF 0..7), count=24, one done pulse, halt_req low after done.
REQ-037 Mode 11 with only RAM[3]=0x5A and RF[7]=0xFF nonzero -> exactly 2 beats {0,3,0x5A} and {1,7,0xFF}, count=2.
REQ-038 Mode 10, out_ready toggling 1-0-1-0 -> 8 beats with payload stable while stalled, no duplicates or drops.
REQ-039 halt_ack delayed 10 cycles -> no rd_en before halt_ack is sampled high; first beat is RAM or RF index 0 as selected.
REQ-040 abort during SEND of RAM index 5, then start again -> out_valid drops next edge, no done pulse, the new dump restarts at index 0 with count=0.
REQ-041 areset pulled low mid-dump, asynchronous to clk -> all outputs reach their reset values immediately, and the next start runs a complete dump.
